tx_clk_lane: RTL and testbench

//  D-PHY clock-lane transmitter: the TX end of the clock lane checked by the RX clock-lane monitor.

---
 rtl/dphy_pkg.sv | 34 +++
 rtl/tx_clk_timer.sv | 29 ++
 rtl/tx_clk_lane.sv | 129 ++++++++++++
 tb/tb_tx_clk_lane.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dphy_pkg.sv
// Shared D-PHY clock-lane definitions: state encoding, LP line states, default timings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dphy_pkg;

    // Clock-lane state, shared by the TX block and the RX clock-lane model
    typedef enum logic [2:0] {
        CLK_STOP  = 3'd0,
        CLK_RQST  = 3'd1,
        CLK_PREP  = 3'd2,
        CLK_ZERO  = 3'd3,
        CLK_HSCLK = 3'd4,
        CLK_POST  = 3'd5,
        CLK_TRAIL = 3'd6,
        CLK_EXIT  = 3'd7
    } clk_state_e;

    // LP line states as {Dp, Dn}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP10 = 2'b10;
    localparam logic [1:0] LP00 = 2'b00;

    // Default timings in core clock cycles
    localparam int DEF_TLPX         = 2;
    localparam int DEF_TCLK_PREPARE = 2;
    localparam int DEF_TCLK_ZERO    = 8;
    localparam int DEF_TCLK_PRE     = 4;
    localparam int DEF_TCLK_POST    = 6;
    localparam int DEF_TCLK_TRAIL   = 3;
    localparam int DEF_THS_EXIT     = 4;
    localparam int DEF_CNT_W        = 8;

endpackage

// File: rtl/tx_clk_timer.sv
// Loadable down-counter timing the clock-lane states; flags when the count reaches zero.
// Latency: load takes effect on the next clock; zero is a combinational decode of the count.
// Backpressure: none; saturates at zero instead of wrapping.
module tx_clk_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Load on state entry, otherwise count down and hold at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tx_clk_lane.sv
// D-PHY clock-lane transmitter: LP-11 stop, LP request/prepare, HS-0, HS toggle, post/trail/exit.
// Latency: hs_req sampled in STOP gives LP-01 on the next cycle; all outputs registered.
// Backpressure: hs_req is a level; it is ignored during entry and tail and honoured only in STOP.
module tx_clk_lane
    import dphy_pkg::*;
#(
    parameter int Tlpx         = DEF_TLPX,
    parameter int Tclk_prepare = DEF_TCLK_PREPARE,
    parameter int Tclk_zero    = DEF_TCLK_ZERO,
    parameter int Tclk_pre     = DEF_TCLK_PRE,
    parameter int Tclk_post    = DEF_TCLK_POST,
    parameter int Tclk_trail   = DEF_TCLK_TRAIL,
    parameter int Ths_exit     = DEF_THS_EXIT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic hs_req,
    output logic hs_ready,
    output logic stop_state,
    output logic hs_mode,
    output logic CLKDp,
    output logic CLKDn
);

    clk_state_e       state_q;
    clk_state_e       state_d;
    logic             timer_zero;
    logic             timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic             tgl_d;
    logic             dp_d;
    logic             dn_d;
    logic             hs_mode_d;
    logic             hs_ready_d;
    logic             stop_state_d;

    // Cycles-minus-one spent in each state; untimed STOP loads zero so the timer rests there
    function automatic logic [CNT_W-1:0] state_len(input clk_state_e s);
        logic [CNT_W-1:0] len;
        case (s)
            CLK_RQST:  len = CNT_W'(Tlpx - 1);
            CLK_PREP:  len = CNT_W'(Tclk_prepare - 1);
            CLK_ZERO:  len = CNT_W'(Tclk_zero - 1);
            CLK_HSCLK: len = CNT_W'(Tclk_pre - 1);
            CLK_POST:  len = CNT_W'(Tclk_post - 1);
            CLK_TRAIL: len = CNT_W'(Tclk_trail - 1);
            CLK_EXIT:  len = CNT_W'(Ths_exit - 1);
            default:   len = '0;
        endcase
        return len;
    endfunction

    tx_clk_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .zero     (timer_zero)
    );

    // Next-state: entry and tail always run to completion; POST waits for CLKDp=1 so the last toggle falls into TRAIL
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLK_STOP:  if (hs_req)                   state_d = CLK_RQST;
            CLK_RQST:  if (timer_zero)               state_d = CLK_PREP;
            CLK_PREP:  if (timer_zero)               state_d = CLK_ZERO;
            CLK_ZERO:  if (timer_zero)               state_d = CLK_HSCLK;
            CLK_HSCLK: if (timer_zero && !hs_req)    state_d = CLK_POST;
            CLK_POST:  if (timer_zero && CLKDp)      state_d = CLK_TRAIL;
            CLK_TRAIL: if (timer_zero)               state_d = CLK_EXIT;
            CLK_EXIT:  if (timer_zero)               state_d = CLK_STOP;
            default:                                 state_d = CLK_STOP;
        endcase
        timer_load     = (state_d != state_q);
        timer_load_val = state_len(state_d);
    end

    // Output decode from the next state so the registered pins line up with the state they belong to
    always_comb begin
        tgl_d        = ((state_q == CLK_HSCLK) || (state_q == CLK_POST)) ? ~CLKDp : 1'b1;
        {dp_d, dn_d} = LP11;
        hs_mode_d    = 1'b0;
        case (state_d)
            CLK_RQST:  {dp_d, dn_d} = LP01;
            CLK_PREP:  {dp_d, dn_d} = LP00;
            CLK_ZERO: begin
                {dp_d, dn_d} = LP01;
                hs_mode_d    = 1'b1;
            end
            CLK_HSCLK, CLK_POST: begin
                dp_d      = tgl_d;
                dn_d      = ~tgl_d;
                hs_mode_d = 1'b1;
            end
            CLK_TRAIL: begin
                {dp_d, dn_d} = LP01;
                hs_mode_d    = 1'b1;
            end
            default:   {dp_d, dn_d} = LP11;
        endcase
        stop_state_d = (state_d == CLK_STOP);
        // Ready only once the pre count has run out and the request is still held
        hs_ready_d   = (state_q == CLK_HSCLK) && timer_zero && hs_req;
    end

    // State and output registers; reset forces LP-11 stop from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLK_STOP;
            CLKDp      <= 1'b1;
            CLKDn      <= 1'b1;
            hs_mode    <= 1'b0;
            hs_ready   <= 1'b0;
            stop_state <= 1'b1;
        end else begin
            state_q    <= state_d;
            CLKDp      <= dp_d;
            CLKDn      <= dn_d;
            hs_mode    <= hs_mode_d;
            hs_ready   <= hs_ready_d;
            stop_state <= stop_state_d;
        end
    end

endmodule

// File: tb/tb_tx_clk_lane.sv
// Self-checking bench for tx_clk_lane: vector table, hand sequences, randomized bursts vs. timeline model.
// Latency: one cycle per vector; outputs checked on the falling edge.
// Backpressure: n/a.
module tb_tx_clk_lane;
    import dphy_pkg::*;

    localparam int TLPX   = DEF_TLPX;
    localparam int TPREP  = DEF_TCLK_PREPARE;
    localparam int TZERO  = DEF_TCLK_ZERO;
    localparam int TPRE   = DEF_TCLK_PRE;
    localparam int TPOST  = DEF_TCLK_POST;
    localparam int TTRAIL = DEF_TCLK_TRAIL;
    localparam int TEXIT  = DEF_THS_EXIT;

    // Expected pins {CLKDp, CLKDn, hs_mode, hs_ready, stop_state}
    typedef struct packed {
        logic dp;
        logic dn;
        logic hm;
        logic rdy;
        logic st;
    } exp_t;

    typedef struct {
        logic r;
        logic q;
        exp_t e;
    } vec_t;

    localparam exp_t E_STOP  = exp_t'(5'b11001);
    localparam exp_t E_RQST  = exp_t'(5'b01000);
    localparam exp_t E_PREP  = exp_t'(5'b00000);
    localparam exp_t E_ZERO  = exp_t'(5'b01100);
    localparam exp_t E_TRAIL = exp_t'(5'b01100);
    localparam exp_t E_EXIT  = exp_t'(5'b11000);

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic hs_req = 1'b0;
    logic hs_ready;
    logic stop_state;
    logic hs_mode;
    logic CLKDp;
    logic CLKDn;

    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc_no   = 0;
    int   rx_edges = 0;
    int   exp_rx   = 0;
    logic rx_prev  = 1'b0;
    logic rx_en    = 1'b0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    tx_clk_lane dut (
        .clk        (clk),
        .rst        (rst),
        .hs_req     (hs_req),
        .hs_ready   (hs_ready),
        .stop_state (stop_state),
        .hs_mode    (hs_mode),
        .CLKDp      (CLKDp),
        .CLKDn      (CLKDn)
    );

    // RX clock-lane receiver: recovers HS clock from the differential pair and counts its rising edges
    always @(negedge clk) begin
        if (rx_en && hs_mode && (CLKDn == ~CLKDp)) begin
            if (CLKDp && !rx_prev) rx_edges <= rx_edges + 1;
            rx_prev <= CLKDp;
        end
    end

    function automatic exp_t e_tgl(input logic dp, input logic rdy);
        return exp_t'({dp, ~dp, 1'b1, rdy, 1'b0});
    endfunction

    function automatic void add(input logic r, input logic q, input exp_t e, input int n);
        vec_t v;
        v.r = r;
        v.q = q;
        v.e = e;
        for (int j = 0; j < n; j++) tbl.push_back(v);
    endfunction

    // Full entry and 11-toggle tail of a request that drops after one cycle (default timings)
    function automatic void add_short_body();
        add(1'b0, 1'b0, E_RQST, TLPX);
        add(1'b0, 1'b0, E_PREP, TPREP);
        add(1'b0, 1'b0, E_ZERO, TZERO);
        for (int k = 0; k < 11; k++) add(1'b0, 1'b0, e_tgl(k % 2 == 0, 1'b0), 1);
        add(1'b0, 1'b0, E_TRAIL, TTRAIL);
        add(1'b0, 1'b0, E_EXIT, TEXIT);
    endfunction

    // Check this cycle's outputs, then drive the inputs sampled at the end of the cycle
    task automatic cyc(input logic r, input logic q, input exp_t e, input string nm);
        exp_t act;
        @(negedge clk);
        act = exp_t'({CLKDp, CLKDn, hs_mode, hs_ready, stop_state});
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got{dp,dn,hm,rdy,st}=%b want=%b", nm, cyc_no, act, e);
        end
        rst    = r;
        hs_req = q;
        cyc_no++;
    endtask

    // Timeline model of one burst, starting in STOP; cycle 0 is the STOP cycle where hs_req is first high
    task automatic run_burst(input int idle, input int req_len, input int rq_phase,
                             input int rq_pos, output bit pending);
        int t0, hs_len, m, post_len, p0, rq_at, n;
        t0       = 1 + TLPX + TPREP + TZERO;
        hs_len   = ((req_len - t0) > (TPRE - 1)) ? (req_len - t0 + 1) : TPRE;
        m        = hs_len + TPOST;
        if (m % 2 == 0) m++;
        post_len = m - hs_len;
        p0       = t0 + hs_len;
        case (rq_phase)
            1:       rq_at = p0 + rq_pos % post_len;
            2:       rq_at = p0 + post_len + rq_pos % TTRAIL;
            3:       rq_at = p0 + post_len + TTRAIL + rq_pos % TEXIT;
            default: rq_at = -1;
        endcase
        for (int j = 0; j < idle; j++) cyc(1'b0, 1'b0, E_STOP, "idle");
        n = t0 + m + TTRAIL + TEXIT;
        for (int i = 0; i < n; i++) begin
            exp_t  e;
            logic  q;
            string nm;
            int    k;
            q = (i < req_len) || ((rq_at >= 0) && (i >= rq_at));
            k = i - t0;
            if (i == 0) begin
                e = E_STOP; nm = "req_stop";
            end else if (i <= TLPX) begin
                e = E_RQST; nm = "lp01";
            end else if (i <= TLPX + TPREP) begin
                e = E_PREP; nm = "lp00";
            end else if (i < t0) begin
                e = E_ZERO; nm = "hs0";
            end else if (k < m) begin
                e  = e_tgl(k % 2 == 0, (k >= TPRE) && (k < hs_len));
                nm = (k < hs_len) ? "hsclk" : "post";
            end else if (k < m + TTRAIL) begin
                e = E_TRAIL; nm = "trail";
            end else begin
                e = E_EXIT; nm = "exit";
            end
            cyc(1'b0, q, e, nm);
        end
        if (rx_en) exp_rx += (m + 1) / 2;
        pending = (rq_at >= 0);
    endtask

    initial begin
        bit pend;

        // Reset, one-cycle request, then a request aborted by reset in POST and a fresh restart
        add(1'b1, 1'b0, E_STOP, 3);
        add(1'b0, 1'b0, E_STOP, 2);
        add(1'b0, 1'b1, E_STOP, 1);
        add_short_body();
        add(1'b0, 1'b0, E_STOP, 1);
        add(1'b0, 1'b1, E_STOP, 1);
        add(1'b0, 1'b0, E_RQST, TLPX);
        add(1'b0, 1'b0, E_PREP, TPREP);
        add(1'b0, 1'b0, E_ZERO, TZERO);
        for (int k = 0; k < 5; k++) add(1'b0, 1'b0, e_tgl(k % 2 == 0, 1'b0), 1);
        add(1'b1, 1'b0, e_tgl(1'b0, 1'b0), 1);
        add(1'b0, 1'b1, E_STOP, 1);
        add_short_body();
        add(1'b0, 1'b0, E_STOP, 2);

        @(posedge clk);
        foreach (tbl[i]) cyc(tbl[i].r, tbl[i].q, tbl[i].e, "vec");

        // Long request: hs_ready from cycle 17, clean exit
        run_burst(1, 30, 0, 0, pend);
        // Back-to-back: request re-raised in TRAIL, next burst starts from the single STOP cycle
        run_burst(1, 20, 2, 0, pend);
        run_burst(0, 16, 0, 0, pend);
        // Request dropped exactly as the pre count ends
        run_burst(2, 16, 0, 0, pend);

        // Randomized bursts with the RX model watching the clock
        rx_en = 1'b1;
        pend  = 1'b0;
        for (int b = 0; b < 40; b++) begin
            int idle, rl, ph, pos;
            idle = pend ? 0 : int'($urandom_range(0, 3));
            rl   = int'($urandom_range(1, 30));
            ph   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            pos  = int'($urandom_range(0, 7));
            run_burst(idle, rl, ph, pos, pend);
        end
        @(negedge clk);
        n_cmp++;
        if (rx_edges != exp_rx) begin
            n_bad++;
            $display("FAIL rx_clk_edges got=%0d want=%0d", rx_edges, exp_rx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
